// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the gh_uart_16550 host-side controller.
// Contents: 16550 register addresses, the DLAB bit, the init step count,
// the controller state type and the bus grant type.
package uart_ctrl_pkg;

  localparam logic [2:0] REG_RBR_THR = 3'd0;
  localparam logic [2:0] REG_IER     = 3'd1;
  localparam logic [2:0] REG_DLL     = 3'd0;
  localparam logic [2:0] REG_DLM     = 3'd1;
  localparam logic [2:0] REG_FCR     = 3'd2;
  localparam logic [2:0] REG_LCR     = 3'd3;

  localparam logic [7:0] LCR_DLAB    = 8'h80;

  // Number of register writes in the initialisation sequence.
  localparam int unsigned INIT_STEPS = 6;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_TX_WR,
    ST_TX_GAP,
    ST_RX_RD0,
    ST_RX_RD1
  } state_t;

  typedef enum logic {
    GRANT_TX,
    GRANT_RX
  } grant_t;

endpackage

// File: rtl/uart_host_ctrl_if.sv
// Register-port bus between the host controller and the gh_uart_16550 core.
// Signals:
//   uart_cs       chip select
//   uart_wr       write strobe (1=write, 0=read)
//   uart_add[2:0] register address
//   uart_d[7:0]   write data
//   uart_rd[7:0]  read data
//   uart_txrdy_n  low = THR/FIFO can accept a byte
//   uart_rxrdy_n  low = RX data available
// Modports: master = controller side, slave = UART side.
interface uart_host_ctrl_if;
  logic       uart_cs;
  logic       uart_wr;
  logic [2:0] uart_add;
  logic [7:0] uart_d;
  logic [7:0] uart_rd;
  logic       uart_txrdy_n;
  logic       uart_rxrdy_n;

  modport master (
    output uart_cs, uart_wr, uart_add, uart_d,
    input  uart_rd, uart_txrdy_n, uart_rxrdy_n
  );

  modport slave (
    input  uart_cs, uart_wr, uart_add, uart_d,
    output uart_rd, uart_txrdy_n, uart_rxrdy_n
  );
endinterface

// File: rtl/uart_init_rom.sv
// Combinational table of the UART initialisation writes.
// Ports:
//   idx[2:0]      in   init step (0..5)
//   divisor[15:0] in   baud divisor latched at the start of INIT
//   add[2:0]      out  register address for this step
//   d[7:0]        out  data for this step
// Step order: LCR with DLAB set, DLL, DLM, LCR (DLAB clear), FCR, IER.
module uart_init_rom
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0] LCR_MODE = 8'h03,
  parameter logic [7:0] FCR_VAL  = 8'h07,
  parameter logic [7:0] IER_VAL  = 8'h00
) (
  input  logic [2:0]  idx,
  input  logic [15:0] divisor,
  output logic [2:0]  add,
  output logic [7:0]  d
);

  always_comb begin
    add = '0;
    d   = '0;
    case (idx)
      3'd0: begin add = REG_LCR; d = LCR_MODE | LCR_DLAB; end
      3'd1: begin add = REG_DLL; d = divisor[7:0];        end
      3'd2: begin add = REG_DLM; d = divisor[15:8];       end
      3'd3: begin add = REG_LCR; d = LCR_MODE;            end
      3'd4: begin add = REG_FCR; d = FCR_VAL;             end
      3'd5: begin add = REG_IER; d = IER_VAL;             end
      default: begin add = '0; d = '0; end
    endcase
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// Sequencer/arbiter in front of the gh_uart_16550 register port.
// After reset (or cfg_start in IDLE) it programs LCR/DLAB, divisor, FCR and
// IER, then shares the single register bus between a TX byte stream and
// RX draining, alternating when both want the bus.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   divisor[15:0]     baud divisor, sampled at the start of INIT
//   cfg_start         re-initialise request, honoured only in IDLE
//   cfg_busy          high while the init sequence runs
//   tx_data/valid/ready  TX byte stream (accept on valid & ready)
//   rx_data/valid/ready  RX byte stream (rx_valid held until rx_ready)
//   bus               UART register bus (master modport)
module uart_host_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0] LCR_MODE = 8'h03,
  parameter logic [7:0] FCR_VAL  = 8'h07,
  parameter logic [7:0] IER_VAL  = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             divisor,
  input  logic                    cfg_start,
  output logic                    cfg_busy,
  input  logic [7:0]              tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  uart_host_ctrl_if.master        bus
);

  state_t      state;
  grant_t      last_grant;
  logic [2:0]  idx;
  logic [15:0] div_q;
  logic        cs_q;
  logic        wr_q;
  logic [2:0]  add_q;
  logic [7:0]  d_q;
  logic [2:0]  rom_add;
  logic [7:0]  rom_d;
  logic        tx_pend;
  logic        rx_pend;
  logic        grant_tx;
  logic        grant_rx;

  uart_init_rom #(
    .LCR_MODE (LCR_MODE),
    .FCR_VAL  (FCR_VAL),
    .IER_VAL  (IER_VAL)
  ) u_rom (
    .idx     (idx),
    .divisor (div_q),
    .add     (rom_add),
    .d       (rom_d)
  );

  // Arbitration: a lone requester wins; with both pending the one not
  // served last time wins.
  always_comb begin
    tx_pend  = tx_valid & ~bus.uart_txrdy_n;
    rx_pend  = ~bus.uart_rxrdy_n & ~rx_valid;
    grant_tx = tx_pend & (~rx_pend | (last_grant == GRANT_RX));
    grant_rx = rx_pend & (~tx_pend | (last_grant == GRANT_TX));
    tx_ready = (state == ST_IDLE) & ~cfg_start & grant_tx;
  end

  always_comb begin
    bus.uart_cs  = cs_q;
    bus.uart_wr  = wr_q;
    bus.uart_add = add_q;
    bus.uart_d   = d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      idx        <= '0;
      div_q      <= '0;
      cfg_busy   <= 1'b1;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      add_q      <= '0;
      d_q        <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      last_grant <= GRANT_TX;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        ST_INIT: begin
          if (idx == 3'(INIT_STEPS)) begin
            state    <= ST_IDLE;
            cfg_busy <= 1'b0;
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;
            add_q    <= '0;
            d_q      <= '0;
          end else begin
            // Step 0 (LCR/DLAB) does not use the divisor, so latching it
            // here is in time for the DLL/DLM steps that follow.
            if (idx == '0) div_q <= divisor;
            cs_q  <= 1'b1;
            wr_q  <= 1'b1;
            add_q <= rom_add;
            d_q   <= rom_d;
            idx   <= idx + 3'd1;
          end
        end

        ST_IDLE: begin
          if (cfg_start) begin
            state    <= ST_INIT;
            idx      <= '0;
            cfg_busy <= 1'b1;
          end else if (grant_tx) begin
            state      <= ST_TX_WR;
            cs_q       <= 1'b1;
            wr_q       <= 1'b1;
            add_q      <= REG_RBR_THR;
            d_q        <= tx_data;
            last_grant <= GRANT_TX;
          end else if (grant_rx) begin
            state      <= ST_RX_RD0;
            cs_q       <= 1'b1;
            wr_q       <= 1'b0;
            add_q      <= REG_RBR_THR;
            d_q        <= '0;
            last_grant <= GRANT_RX;
          end
        end

        ST_TX_WR: begin
          // Deselect for one cycle so TXRDYn reflects this byte.
          state <= ST_TX_GAP;
          cs_q  <= 1'b0;
          wr_q  <= 1'b0;
          add_q <= '0;
          d_q   <= '0;
        end

        ST_TX_GAP: state <= ST_IDLE;

        ST_RX_RD0: state <= ST_RX_RD1;

        ST_RX_RD1: begin
          state    <= ST_IDLE;
          rx_data  <= bus.uart_rd;
          rx_valid <= 1'b1;
          cs_q     <= 1'b0;
          wr_q     <= 1'b0;
          add_q    <= '0;
          d_q      <= '0;
        end

        default: begin
          state    <= ST_INIT;
          idx      <= '0;
          cfg_busy <= 1'b1;
          cs_q     <= 1'b0;
          wr_q     <= 1'b0;
          add_q    <= '0;
          d_q      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: directed init/TX/RX/arbitration/
// reset steps plus a randomized traffic phase checked against queue-based
// expectations of the TX and RX byte streams.
module tb_uart_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] divisor;
  logic        cfg_start;
  logic        cfg_busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  uart_host_ctrl_if bus ();

  uart_host_ctrl #(
    .LCR_MODE (8'h03),
    .FCR_VAL  (8'h07),
    .IER_VAL  (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .divisor   (divisor),
    .cfg_start (cfg_start),
    .cfg_busy  (cfg_busy),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected {add, data} of each init write, straight from the register map.
  function automatic logic [10:0] init_exp(input int k, input logic [15:0] dv);
    case (k)
      0:       return {3'd3, 8'h83};
      1:       return {3'd0, dv[7:0]};
      2:       return {3'd1, dv[15:8]};
      3:       return {3'd3, 8'h03};
      4:       return {3'd2, 8'h07};
      default: return {3'd1, 8'h00};
    endcase
  endfunction

  // Called while the DUT sits at the start of INIT with the bus idle.
  task automatic check_init(input logic [15:0] dv);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("init_cs",   32'(bus.uart_cs), 1);
      chk("init_wr",   32'(bus.uart_wr), 1);
      chk("init_busy", 32'(cfg_busy), 1);
      chk("init_add_d", 32'({bus.uart_add, bus.uart_d}), 32'(init_exp(k, dv)));
    end
    cyc();
    chk("init_done_busy", 32'(cfg_busy), 0);
    chk("init_done_cs",   32'(bus.uart_cs), 0);
  endtask

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       grants[$];
  logic       found;
  logic       prev_cs;
  logic       accepted;
  logic [7:0] exp_b;
  int         read_run;
  int         tx_count;
  logic [15:0] rdiv;

  initial begin
    rst_n            = 1'b0;
    divisor          = 16'd54;
    cfg_start        = 1'b0;
    tx_valid         = 1'b0;
    tx_data          = '0;
    rx_ready         = 1'b0;
    bus.uart_rd      = '0;
    bus.uart_txrdy_n = 1'b1;
    bus.uart_rxrdy_n = 1'b1;

    // Reset state
    repeat (3) cyc();
    chk("rst_cs",       32'(bus.uart_cs), 0);
    chk("rst_wr",       32'(bus.uart_wr), 0);
    chk("rst_add_d",    32'({bus.uart_add, bus.uart_d}), 0);
    chk("rst_busy",     32'(cfg_busy), 1);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data",  32'(rx_data), 0);

    // Init after reset release
    rst_n = 1'b1;
    check_init(16'd54);

    // Single TX byte, then a back-to-back byte at the minimum period
    tx_data = 8'hAA; tx_valid = 1'b1; bus.uart_txrdy_n = 1'b0;
    #1;
    chk("t2_ready_idle", 32'(tx_ready), 1);
    cyc();
    chk("t2_wr_cs",    32'(bus.uart_cs), 1);
    chk("t2_wr_wr",    32'(bus.uart_wr), 1);
    chk("t2_wr_add",   32'(bus.uart_add), 0);
    chk("t2_wr_d",     32'(bus.uart_d), 'hAA);
    chk("t2_wr_ready", 32'(tx_ready), 0);
    tx_data = 8'h55;
    cyc();
    chk("t2_gap_cs",    32'(bus.uart_cs), 0);
    chk("t2_gap_add_d", 32'({bus.uart_wr, bus.uart_add, bus.uart_d}), 0);
    chk("t2_gap_ready", 32'(tx_ready), 0);
    cyc();
    chk("t2_idle_ready", 32'(tx_ready), 1);
    chk("t2_idle_cs",    32'(bus.uart_cs), 0);
    cyc();
    chk("t2_second_d", 32'(bus.uart_d), 'h55);
    tx_valid = 1'b0;
    cyc();
    cyc();

    // TX blocked by TXRDYn
    bus.uart_txrdy_n = 1'b1; tx_valid = 1'b1; tx_data = 8'h3C;
    #1;
    chk("t3_blocked_ready", 32'(tx_ready), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_blocked_cs", 32'(bus.uart_cs), 0);
    end
    bus.uart_txrdy_n = 1'b0;
    #1;
    chk("t3_unblocked_ready", 32'(tx_ready), 1);
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      cyc();
      if (bus.uart_cs) found = 1'b1;
    end
    chk("t3_write_seen", 32'(found), 1);
    chk("t3_write_d",    32'(bus.uart_d), 'h3C);
    tx_valid = 1'b0;
    cyc();
    cyc();

    // RX read and backpressure
    bus.uart_txrdy_n = 1'b1;
    bus.uart_rxrdy_n = 1'b0; bus.uart_rd = 8'h5C; rx_ready = 1'b0;
    cyc();
    chk("t4_rd0", 32'({bus.uart_cs, bus.uart_wr, bus.uart_add}), 32'({1'b1, 1'b0, 3'd0}));
    cyc();
    chk("t4_rd1", 32'({bus.uart_cs, bus.uart_wr, bus.uart_add}), 32'({1'b1, 1'b0, 3'd0}));
    cyc();
    chk("t4_valid", 32'(rx_valid), 1);
    chk("t4_data",  32'(rx_data), 'h5C);
    chk("t4_cs",    32'(bus.uart_cs), 0);
    bus.uart_rd = 8'h11;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_hold_cs",    32'(bus.uart_cs), 0);
      chk("t4_hold_valid", 32'(rx_valid), 1);
      chk("t4_hold_data",  32'(rx_data), 'h5C);
    end
    rx_ready = 1'b1;
    cyc();
    rx_ready = 1'b0;
    chk("t4_cleared", 32'(rx_valid), 0);
    cyc();
    chk("t4_next_read", 32'({bus.uart_cs, bus.uart_wr}), 32'(2'b10));
    cyc();
    cyc();
    chk("t4_valid2", 32'(rx_valid), 1);
    chk("t4_data2",  32'(rx_data), 'h11);
    bus.uart_rxrdy_n = 1'b1; rx_ready = 1'b1;
    cyc();
    rx_ready = 1'b0;
    chk("t4_cleared2", 32'(rx_valid), 0);

    // Alternation with TX and RX both permanently pending (last grant was RX)
    tx_valid = 1'b1; tx_data = 8'($urandom); bus.uart_txrdy_n = 1'b0;
    bus.uart_rxrdy_n = 1'b0; bus.uart_rd = 8'($urandom); rx_ready = 1'b1;
    prev_cs = 1'b0;
    grants.delete();
    for (int i = 0; i < 200 && grants.size() < 10; i++) begin
      cyc();
      if (bus.uart_cs && !prev_cs) grants.push_back(bus.uart_wr);
      if (bus.uart_cs && bus.uart_wr) begin
        chk("t5_tx_d", 32'(bus.uart_d), 32'(tx_data));
        tx_data = 8'($urandom);
      end
      if (rx_valid) begin
        chk("t5_rx_d", 32'(rx_data), 32'(bus.uart_rd));
        bus.uart_rd = 8'($urandom);
      end
      prev_cs = bus.uart_cs;
    end
    chk("t5_grant_count", 32'(grants.size()), 10);
    foreach (grants[i]) chk("t5_grant_order", 32'(grants[i]), (i % 2 == 0) ? 1 : 0);
    tx_valid = 1'b0; bus.uart_rxrdy_n = 1'b1; bus.uart_txrdy_n = 1'b1;
    repeat (6) cyc();
    rx_ready = 1'b0;
    repeat (2) cyc();

    // Randomized traffic against queue expectations
    txq.delete(); rxq.delete();
    read_run = 0; tx_count = 0; accepted = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      if (!bus.uart_cs)
        chk("r_idle_bus", 32'({bus.uart_wr, bus.uart_add, bus.uart_d}), 0);
      else
        chk("r_busy_no_ready", 32'(tx_ready), 0);
      if (bus.uart_cs && !bus.uart_wr) begin
        chk("r_rd_add", 32'(bus.uart_add), 0);
        chk("r_rd_while_valid", 32'(rx_valid), 0);
        read_run++;
      end else begin
        if (read_run != 0) chk("r_rd_len", read_run, 2);
        read_run = 0;
      end
      if (bus.uart_cs && bus.uart_wr) begin
        chk("r_wr_add", 32'(bus.uart_add), 0);
        chk("r_wr_expected", 32'(txq.size() > 0), 1);
        if (txq.size() > 0) begin
          exp_b = txq.pop_front();
          chk("r_wr_d", 32'(bus.uart_d), 32'(exp_b));
        end
      end

      bus.uart_rd = 8'($urandom);
      if (read_run == 2) rxq.push_back(bus.uart_rd);
      if (!tx_valid || accepted) begin
        tx_valid = ($urandom_range(0, 2) != 0);
        tx_data  = 8'($urandom);
      end
      bus.uart_txrdy_n = ($urandom_range(0, 3) == 0);
      bus.uart_rxrdy_n = ($urandom_range(0, 2) == 0);
      rx_ready         = 1'($urandom);
      #1;
      accepted = tx_valid && tx_ready;
      if (accepted) begin
        txq.push_back(tx_data);
        tx_count++;
      end
      if (rx_valid && rx_ready) begin
        chk("r_rx_expected", 32'(rxq.size() > 0), 1);
        if (rxq.size() > 0) begin
          exp_b = rxq.pop_front();
          chk("r_rx_d", 32'(rx_data), 32'(exp_b));
        end
      end
    end
    chk("r_tx_traffic", 32'(tx_count > 50), 1);

    // Re-init via cfg_start (wins over a pending TX), then reset mid-write
    tx_valid = 1'b0; bus.uart_rxrdy_n = 1'b1; bus.uart_txrdy_n = 1'b1; rx_ready = 1'b1;
    repeat (6) cyc();
    rx_ready = 1'b0;
    divisor = 16'h0102; cfg_start = 1'b1;
    tx_valid = 1'b1; tx_data = 8'hC3; bus.uart_txrdy_n = 1'b0;
    #1;
    chk("t6_cfg_priority", 32'(tx_ready), 0);
    cyc();
    cfg_start = 1'b0; tx_valid = 1'b0;
    chk("t6_busy", 32'(cfg_busy), 1);
    chk("t6_cs",   32'(bus.uart_cs), 0);
    check_init(16'h0102);

    tx_valid = 1'b1; tx_data = 8'hC3;
    cyc();
    tx_valid = 1'b0;
    chk("t6_tx_wr", 32'({bus.uart_cs, bus.uart_d}), 32'({1'b1, 8'hC3}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bus",   32'({bus.uart_cs, bus.uart_wr, bus.uart_add, bus.uart_d}), 0);
    chk("t6_rst_busy",  32'(cfg_busy), 1);
    chk("t6_rst_ready", 32'(tx_ready), 0);
    cyc();
    rst_n = 1'b1;
    check_init(16'h0102);

    // Random divisor through cfg_start
    rdiv = 16'($urandom);
    divisor = rdiv; cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    check_init(rdiv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
